// File: rtl/ps2_packet_assembler.sv
// ps2_packet_assembler
//   Collects 3-byte (standard) or 4-byte (wheel) PS/2 mouse packets from a
//   byte receiver and decodes them into button states, scaled movement
//   magnitudes, direction flags and an optional wheel delta.
//
// Parameters
//   PKT_BYTES : 3 or 4 bytes per packet
//   VEL_W     : width of vx/vy (4..10)
//   SHIFT     : right shift applied to movement magnitude (0..3)
//   TIMEOUT   : idle clk cycles before a partial packet is abandoned
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   byte_ready        : receiver level, a rising edge marks a new byte
//   byte_data         : received byte, stable while byte_ready is high
//   pkt_valid         : one-cycle pulse when decoded outputs update
//   btn_left/right/middle : buttons from byte 0 bits 0..2
//   vx, vy            : saturated, shifted movement magnitudes
//   dx, dy            : 1 = non-negative movement
//   wheel             : byte 3 bits 3:0 (0 in 3-byte mode)
//   sync_err          : pulse when a first byte without bit 3 is dropped
//   timeout           : pulse when a partial packet is abandoned
module ps2_packet_assembler #(
   parameter int PKT_BYTES = 3,
   parameter int VEL_W     = 10,
   parameter int SHIFT     = 1,
   parameter int TIMEOUT   = 10000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             byte_ready,
   input  logic [7:0]       byte_data,
   output logic             pkt_valid,
   output logic             btn_left,
   output logic             btn_right,
   output logic             btn_middle,
   output logic [VEL_W-1:0] vx,
   output logic [VEL_W-1:0] vy,
   output logic             dx,
   output logic             dy,
   output logic [3:0]       wheel,
   output logic             sync_err,
   output logic             timeout
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [10:0] VMAX = 11'((1 << VEL_W) - 1);

   typedef enum logic [1:0] {IDLE, B1, B2, B3} state_t;

   state_t state, state_n;

   logic sync1, sync2, sync3;
   logic byte_edge;

   logic [CNT_W-1:0] idle_cnt;

   // Byte 0 is kept as its individual fields; bit 3 is only a sync marker.
   logic [2:0] btns;
   logic       x_sign, y_sign, x_ovf, y_ovf;
   logic [7:0] b1, b2;
   logic [3:0] b3;
   logic       done;

   logic take0, take1, take2, take3;
   logic last, sync_err_n, timeout_n;

   // Synchroniser plus one extra stage for rising-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= byte_ready;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign byte_edge = sync2 & ~sync3;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n    = state;
      take0      = 1'b0;
      take1      = 1'b0;
      take2      = 1'b0;
      take3      = 1'b0;
      last       = 1'b0;
      sync_err_n = 1'b0;
      timeout_n  = 1'b0;
      case (state)
         IDLE: begin
            if (byte_edge) begin
               if (byte_data[3]) begin
                  take0   = 1'b1;
                  state_n = B1;
               end else begin
                  sync_err_n = 1'b1;
               end
            end
         end
         B1: begin
            if (byte_edge) begin
               take1   = 1'b1;
               state_n = B2;
            end else if (idle_cnt == CNT_LAST) begin
               timeout_n = 1'b1;
               state_n   = IDLE;
            end
         end
         B2: begin
            if (byte_edge) begin
               take2 = 1'b1;
               if (PKT_BYTES == 4) begin
                  state_n = B3;
               end else begin
                  last    = 1'b1;
                  state_n = IDLE;
               end
            end else if (idle_cnt == CNT_LAST) begin
               timeout_n = 1'b1;
               state_n   = IDLE;
            end
         end
         B3: begin
            if (byte_edge) begin
               take3   = 1'b1;
               last    = 1'b1;
               state_n = IDLE;
            end else if (idle_cnt == CNT_LAST) begin
               timeout_n = 1'b1;
               state_n   = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Idle counter only runs mid-packet; any byte restarts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if (state == IDLE || byte_edge || timeout_n) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         btns   <= '0;
         x_sign <= 1'b0;
         y_sign <= 1'b0;
         x_ovf  <= 1'b0;
         y_ovf  <= 1'b0;
         b1     <= '0;
         b2     <= '0;
         b3     <= '0;
         done   <= 1'b0;
      end else begin
         if (take0) begin
            btns   <= byte_data[2:0];
            x_sign <= byte_data[4];
            y_sign <= byte_data[5];
            x_ovf  <= byte_data[6];
            y_ovf  <= byte_data[7];
         end
         if (take1) b1 <= byte_data;
         if (take2) b2 <= byte_data;
         if (take3) b3 <= byte_data[3:0];
         // Decode happens one cycle after the final byte lands in its register
         done <= last;
      end
   end

   function automatic logic [VEL_W-1:0] scale(input logic [8:0] v, input logic ovf);
      logic [8:0]  mag;
      logic [10:0] shifted;
      mag = v[8] ? (~v + 9'd1) : v;
      if (ovf) mag = 9'd255;
      shifted = {2'b00, mag} >> SHIFT;
      if (shifted > VMAX) shifted = VMAX;
      return shifted[VEL_W-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_valid  <= 1'b0;
         btn_left   <= 1'b0;
         btn_right  <= 1'b0;
         btn_middle <= 1'b0;
         vx         <= '0;
         vy         <= '0;
         dx         <= 1'b1;
         dy         <= 1'b1;
         wheel      <= '0;
         sync_err   <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         pkt_valid <= done;
         sync_err  <= sync_err_n;
         timeout   <= timeout_n;
         if (done) begin
            btn_left   <= btns[0];
            btn_right  <= btns[1];
            btn_middle <= btns[2];
            vx         <= scale({x_sign, b1}, x_ovf);
            vy         <= scale({y_sign, b2}, y_ovf);
            dx         <= ~x_sign;
            dy         <= ~y_sign;
            wheel      <= (PKT_BYTES == 4) ? b3 : 4'd0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_packet_assembler.sv
// Bench for ps2_packet_assembler: four instances with different parameter
// sets, each with its own byte stream, checked against an arithmetic model.
module tb_ps2_packet_assembler;

   logic clk;
   logic rst;

   logic       rdy [4];
   logic [7:0] dat [4];

   logic       pv [4];
   logic       bl [4];
   logic       brt[4];
   logic       bm [4];
   logic [9:0] vxo[4];
   logic [9:0] vyo[4];
   logic       dxo[4];
   logic       dyo[4];
   logic [3:0] wh [4];
   logic       se [4];
   logic       too[4];

   logic [5:0] vx_c, vy_c;

   // 0: defaults, 1: TIMEOUT=100, 2: VEL_W=6 SHIFT=0, 3: 4-byte SHIFT=2
   int P_PB   [4] = '{3, 3, 3, 4};
   int P_SH   [4] = '{1, 1, 0, 2};
   int P_VW   [4] = '{10, 10, 6, 10};

   int n_tests = 0;
   int n_fail  = 0;

   int pv_cnt[4] = '{0, 0, 0, 0};
   int se_cnt[4] = '{0, 0, 0, 0};
   int to_cnt[4] = '{0, 0, 0, 0};

   int   e_pv[4] = '{0, 0, 0, 0};
   int   e_se[4] = '{0, 0, 0, 0};
   int   e_to[4] = '{0, 0, 0, 0};
   logic e_bl[4], e_br[4], e_bm[4], e_dx[4], e_dy[4];
   int   e_vx[4], e_vy[4], e_wh[4];

   ps2_packet_assembler u_def (
      .clk(clk), .rst(rst), .byte_ready(rdy[0]), .byte_data(dat[0]),
      .pkt_valid(pv[0]), .btn_left(bl[0]), .btn_right(brt[0]), .btn_middle(bm[0]),
      .vx(vxo[0]), .vy(vyo[0]), .dx(dxo[0]), .dy(dyo[0]), .wheel(wh[0]),
      .sync_err(se[0]), .timeout(too[0])
   );

   ps2_packet_assembler #(.TIMEOUT(100)) u_to (
      .clk(clk), .rst(rst), .byte_ready(rdy[1]), .byte_data(dat[1]),
      .pkt_valid(pv[1]), .btn_left(bl[1]), .btn_right(brt[1]), .btn_middle(bm[1]),
      .vx(vxo[1]), .vy(vyo[1]), .dx(dxo[1]), .dy(dyo[1]), .wheel(wh[1]),
      .sync_err(se[1]), .timeout(too[1])
   );

   ps2_packet_assembler #(.VEL_W(6), .SHIFT(0)) u_sat (
      .clk(clk), .rst(rst), .byte_ready(rdy[2]), .byte_data(dat[2]),
      .pkt_valid(pv[2]), .btn_left(bl[2]), .btn_right(brt[2]), .btn_middle(bm[2]),
      .vx(vx_c), .vy(vy_c), .dx(dxo[2]), .dy(dyo[2]), .wheel(wh[2]),
      .sync_err(se[2]), .timeout(too[2])
   );

   assign vxo[2] = {4'b0000, vx_c};
   assign vyo[2] = {4'b0000, vy_c};

   ps2_packet_assembler #(.PKT_BYTES(4), .SHIFT(2)) u_whl (
      .clk(clk), .rst(rst), .byte_ready(rdy[3]), .byte_data(dat[3]),
      .pkt_valid(pv[3]), .btn_left(bl[3]), .btn_right(brt[3]), .btn_middle(bm[3]),
      .vx(vxo[3]), .vy(vyo[3]), .dx(dxo[3]), .dy(dyo[3]), .wheel(wh[3]),
      .sync_err(se[3]), .timeout(too[3])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters: a pulse wider than one cycle is counted more than once.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (pv[i]  === 1'b1) pv_cnt[i]++;
         if (se[i]  === 1'b1) se_cnt[i]++;
         if (too[i] === 1'b1) to_cnt[i]++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int scale_ref(input int raw, input bit neg, input bit ovf,
                                    input int sh, input int vw);
      int v, m, lim;
      v = neg ? raw - 256 : raw;
      m = (v < 0) ? -v : v;
      if (ovf) m = 255;
      m = m / (1 << sh);
      lim = (1 << vw) - 1;
      return (m > lim) ? lim : m;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 4; d++) begin
         e_bl[d] = 1'b0; e_br[d] = 1'b0; e_bm[d] = 1'b0;
         e_vx[d] = 0;    e_vy[d] = 0;
         e_dx[d] = 1'b1; e_dy[d] = 1'b1;
         e_wh[d] = 0;
      end
   endtask

   task automatic model_pkt(input int d, input logic [31:0] b);
      logic [7:0] b0, b1, b2, b3;
      b0 = b[7:0]; b1 = b[15:8]; b2 = b[23:16]; b3 = b[31:24];
      e_bl[d] = b0[0];
      e_br[d] = b0[1];
      e_bm[d] = b0[2];
      e_vx[d] = scale_ref(int'(b1), b0[4], b0[6], P_SH[d], P_VW[d]);
      e_vy[d] = scale_ref(int'(b2), b0[5], b0[7], P_SH[d], P_VW[d]);
      e_dx[d] = ~b0[4];
      e_dy[d] = ~b0[5];
      e_wh[d] = (P_PB[d] == 4) ? int'(b3[3:0]) : 0;
      e_pv[d]++;
   endtask

   task automatic check_dut(input int d, input string tag);
      chk({tag, ".pkt_cnt"}, pv_cnt[d], e_pv[d]);
      chk({tag, ".serr_cnt"}, se_cnt[d], e_se[d]);
      chk({tag, ".tmo_cnt"}, to_cnt[d], e_to[d]);
      chk({tag, ".btn_left"}, bl[d], e_bl[d]);
      chk({tag, ".btn_right"}, brt[d], e_br[d]);
      chk({tag, ".btn_middle"}, bm[d], e_bm[d]);
      chk({tag, ".vx"}, vxo[d], e_vx[d]);
      chk({tag, ".vy"}, vyo[d], e_vy[d]);
      chk({tag, ".dx"}, dxo[d], e_dx[d]);
      chk({tag, ".dy"}, dyo[d], e_dy[d]);
      chk({tag, ".wheel"}, wh[d], e_wh[d]);
   endtask

   task automatic send_byte(input int d, input logic [7:0] b, input int hold);
      @(negedge clk);
      dat[d] = b;
      rdy[d] = 1'b1;
      repeat (hold) @(negedge clk);
      rdy[d] = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_pkt(input int d, input logic [31:0] b);
      for (int i = 0; i < P_PB[d]; i++) send_byte(d, b[8*i +: 8], 4);
      model_pkt(d, b);
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 4; d++) begin
         rdy[d] = 1'b0;
         dat[d] = 8'h00;
      end
      model_reset();
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 4; d++) check_dut(d, $sformatf("reset%0d", d));

      // Basic decode with default parameters
      send_pkt(0, 32'h00F01029);
      check_dut(0, "basic");
      chk("basic.vx_const", vxo[0], 8);
      chk("basic.vy_const", vyo[0], 8);
      chk("basic.dy_const", dyo[0], 0);

      // pkt_valid lands exactly 3 cycles after the final byte is first sampled
      send_byte(0, 8'h08, 4);
      send_byte(0, 8'h44, 4);
      @(negedge clk);
      dat[0] = 8'h90;
      rdy[0] = 1'b1;
      repeat (3) @(negedge clk);
      chk("lat.early", pv[0], 1'b0);
      @(negedge clk);
      chk("lat.pulse", pv[0], 1'b1);
      @(negedge clk);
      chk("lat.after", pv[0], 1'b0);
      rdy[0] = 1'b0;
      repeat (3) @(negedge clk);
      model_pkt(0, 32'h00904408);
      check_dut(0, "lat");

      // First byte without bit 3 is rejected
      send_byte(0, 8'h01, 4);
      e_se[0]++;
      check_dut(0, "serr");
      send_pkt(0, 32'h00000008);
      check_dut(0, "serr_next");
      chk("serr_next.vx_const", vxo[0], 0);

      // A long byte_ready high is still only one byte
      send_byte(0, 8'h08, 20);
      send_byte(0, 8'h20, 4);
      send_byte(0, 8'h40, 4);
      model_pkt(0, 32'h00402008);
      check_dut(0, "hold");

      // Partial packet abandoned after TIMEOUT idle cycles
      send_byte(1, 8'h08, 4);
      send_byte(1, 8'h05, 4);
      for (int k = 0; k < 200 && to_cnt[1] == e_to[1]; k++) @(negedge clk);
      e_to[1]++;
      check_dut(1, "tmo");
      send_pkt(1, 32'h00040208);
      check_dut(1, "tmo_next");
      chk("tmo_next.vx_const", vxo[1], 1);
      chk("tmo_next.vy_const", vyo[1], 2);

      // Byte arriving on the exact expiry cycle wins over the timeout
      send_byte(1, 8'h09, 4);
      @(negedge clk);
      dat[1] = 8'h06;
      rdy[1] = 1'b1;
      repeat (4) @(negedge clk);
      rdy[1] = 1'b0;
      repeat (96) @(negedge clk);
      dat[1] = 8'h04;
      rdy[1] = 1'b1;
      repeat (4) @(negedge clk);
      rdy[1] = 1'b0;
      repeat (3) @(negedge clk);
      model_pkt(1, 32'h00040609);
      check_dut(1, "prio");

      // Overflow and saturation
      send_pkt(2, 32'h000000D8);
      check_dut(2, "sat");
      chk("sat.vx_const", vxo[2], 63);
      chk("sat.vy_const", vyo[2], 63);

      // Wheel mode: three bytes are not a packet
      send_byte(3, 8'h08, 4);
      send_byte(3, 8'h00, 4);
      send_byte(3, 8'h00, 4);
      check_dut(3, "whl3");
      send_byte(3, 8'h0F, 4);
      model_pkt(3, 32'h0F000008);
      check_dut(3, "whl4");
      chk("whl4.wheel_const", wh[3], 4'hF);

      // Randomized packets, sometimes preceded by a rejected byte
      for (int r = 0; r < 10; r++) begin
         for (int s = 0; s < 3; s++) begin
            int d;
            logic [31:0] b;
            d = (s == 0) ? 0 : (s == 1) ? 2 : 3;
            if ($urandom_range(3) == 0) begin
               send_byte(d, 8'($urandom) & 8'hF7, 4);
               e_se[d]++;
            end
            b = $urandom;
            b[3] = 1'b1;
            send_pkt(d, b);
            check_dut(d, $sformatf("rnd%0d_%0d", d, r));
         end
      end

      // Reset in the middle of a packet
      send_byte(0, 8'h0F, 4);
      send_byte(0, 8'h33, 4);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (10) @(negedge clk);
      for (int d = 0; d < 4; d++) check_dut(d, $sformatf("midrst%0d", d));
      send_pkt(0, 32'h00801E3A);
      check_dut(0, "midrst_next");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
